// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-port arbiter for a single-port sync memory (optional ARB_PERF_CNT_EN stall counters)
module mem_port_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          LoadReq,
  input  logic [AW-1:0] LoadAddr,
  input  logic [DW-1:0] LoadWData,
  output logic          LoadAck,
  input  logic          FetchReq,
  input  logic [AW-1:0] FetchAddr,
  output logic [DW-1:0] FetchRData,
  output logic          FetchAck,
  input  logic          DataReq,
  input  logic          DataWe,
  input  logic [AW-1:0] DataAddr,
  input  logic [DW-1:0] DataWData,
  output logic [DW-1:0] DataRData,
  output logic          DataAck,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic          FetchStall,
  output logic          DataStall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   FetchStallCnt,
  output logic [31:0]   DataStallCnt
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {SEL_LOAD, SEL_DATA, SEL_FETCH} sel_t;

  state_t        state, nextState;
  sel_t          grant, pick;
  logic [2:0]    latCnt;
  logic [SW-1:0] starveCnt;
  logic          anyReq;
  logic          pickWe;
  logic [AW-1:0] pickAddr;
  logic [DW-1:0] pickWData;

  // Winner selection: Load first, then Data, unless Fetch has been starved long enough
  always_comb begin
    anyReq    = LoadReq | DataReq | FetchReq;
    pick      = SEL_FETCH;
    pickWe    = 1'b0;
    pickAddr  = FetchAddr;
    pickWData = '0;
    if (LoadReq) begin
      pick      = SEL_LOAD;
      pickWe    = 1'b1;
      pickAddr  = LoadAddr;
      pickWData = LoadWData;
    end else if (DataReq && !(FetchReq && starveCnt == SW'(STARVE_LIMIT))) begin
      pick      = SEL_DATA;
      pickWe    = DataWe;
      pickAddr  = DataAddr;
      pickWData = DataWData;
    end
  end

  // Next-state logic; WAIT ends when the latency count would reach zero
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   nextState = (MEM_LAT == 1) ? ACK : WAIT;
      WAIT:    if (latCnt == 3'd1) nextState = ACK;
      default: nextState = IDLE;
    endcase
  end

  // State, latched grant, registered memory interface, acks and starvation tracking
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      grant     <= SEL_LOAD;
      latCnt    <= '0;
      starveCnt <= '0;
      MemEn     <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      LoadAck   <= 1'b0;
      DataAck   <= 1'b0;
      FetchAck  <= 1'b0;
    end else begin
      state    <= nextState;
      MemEn    <= 1'b0;
      LoadAck  <= (nextState == ACK) && (grant == SEL_LOAD);
      DataAck  <= (nextState == ACK) && (grant == SEL_DATA);
      FetchAck <= (nextState == ACK) && (grant == SEL_FETCH);
      case (state)
        IDLE: begin
          if (!FetchReq) starveCnt <= '0;
          if (anyReq) begin
            grant    <= pick;
            MemEn    <= 1'b1;
            MemWe    <= pickWe;
            MemAddr  <= pickAddr;
            MemWData <= pickWData;
            if (pick == SEL_FETCH) starveCnt <= '0;
            else if (pick == SEL_DATA && FetchReq && starveCnt != SW'(STARVE_LIMIT))
              starveCnt <= starveCnt + 1'b1;
          end
        end
        ISSUE:   latCnt <= 3'(MEM_LAT - 1);
        WAIT:    latCnt <= latCnt - 3'd1;
        default: ;
      endcase
    end
  end

  assign FetchRData = MemRData;
  assign DataRData  = MemRData;
  assign FetchStall = FetchReq & ~FetchAck;
  assign DataStall  = DataReq & ~DataAck;

`ifdef ARB_PERF_CNT_EN
  // Saturating counts of cycles spent stalled
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      FetchStallCnt <= '0;
      DataStallCnt  <= '0;
    end else begin
      if (FetchStall && FetchStallCnt != 32'hFFFF_FFFF) FetchStallCnt <= FetchStallCnt + 32'd1;
      if (DataStall && DataStallCnt != 32'hFFFF_FFFF) DataStallCnt <= DataStallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MEM_LAT = 3;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic LoadReq = 1'b0, FetchReq = 1'b0, DataReq = 1'b0, DataWe = 1'b0;
  logic [AW-1:0] LoadAddr = '0, FetchAddr = '0, DataAddr = '0;
  logic [DW-1:0] LoadWData = '0, DataWData = '0, MemRData = '0;
  logic LoadAck, FetchAck, DataAck, MemEn, MemWe, FetchStall, DataStall;
  logic [DW-1:0] FetchRData, DataRData, MemWData;
  logic [AW-1:0] MemAddr;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] FetchStallCnt, DataStallCnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.DW(DW), .AW(AW), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .Reset(Reset),
    .LoadReq(LoadReq), .LoadAddr(LoadAddr), .LoadWData(LoadWData), .LoadAck(LoadAck),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchRData(FetchRData), .FetchAck(FetchAck),
    .DataReq(DataReq), .DataWe(DataWe), .DataAddr(DataAddr), .DataWData(DataWData),
    .DataRData(DataRData), .DataAck(DataAck),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
    .FetchStall(FetchStall), .DataStall(DataStall)
`ifdef ARB_PERF_CNT_EN
    , .FetchStallCnt(FetchStallCnt), .DataStallCnt(DataStallCnt)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            gap;
  } cmd_t;

  typedef struct {
    int            who;
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  int checks = 0, failures = 0;
  cmd_t lq[$], dq[$], fq[$];
  bit act[3];
  exp_t issQ[$], ackQ[$];
  logic [DW-1:0] mem[64];
  logic [DW-1:0] shadow[64];
  int cyc = 0, busy = 0, starve = 0, memEnCnt = 0;
  int fStallCnt = 0, dStallCnt = 0;
  string ackLog = "", weLog = "";
  logic [DW-1:0] lastData = '0, lastFetch = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chkStr(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%s exp=%s", name, got, exp);
    end
  endtask

  function automatic cmd_t mk(input int addr, input bit we, input logic [DW-1:0] wd, input int gap);
    cmd_t c;
    c.addr = AW'(addr); c.we = we; c.wdata = wd; c.gap = gap;
    return c;
  endfunction

  // Memory behind the arbiter: write on enable, read result held until the next read
  always @(posedge clk) begin
    if (MemEn) begin
      if (MemWe) mem[MemAddr[5:0]] <= MemWData;
      else MemRData <= mem[MemAddr[5:0]];
    end
  end

  function automatic int qsize(input int id);
    return (id == 0) ? lq.size() : (id == 1) ? dq.size() : fq.size();
  endfunction

  task automatic qpop(input int id, output cmd_t c);
    if (id == 0) c = lq.pop_front();
    else if (id == 1) c = dq.pop_front();
    else c = fq.pop_front();
  endtask

  function automatic logic ackOf(input int id);
    return (id == 0) ? LoadAck : (id == 1) ? DataAck : FetchAck;
  endfunction

  task automatic drive(input int id, input logic r, input cmd_t c);
    case (id)
      0: begin LoadReq = r; LoadAddr = c.addr; LoadWData = c.wdata; end
      1: begin DataReq = r; DataWe = c.we; DataAddr = c.addr; DataWData = c.wdata; end
      default: begin FetchReq = r; FetchAddr = c.addr; end
    endcase
  endtask

  // One requester: holds a command until its Ack, then takes the next one
  task automatic serve(input int id);
    cmd_t c;
    int n;
    bit got;
    forever begin
      if (qsize(id) == 0 || !Reset) begin
        @(posedge clk); #1;
        continue;
      end
      qpop(id, c);
      act[id] = 1'b1;
      if (c.gap > 0) begin
        repeat (c.gap) @(posedge clk);
        #1;
      end
      drive(id, 1'b1, c);
      n = 0; got = 1'b0;
      while (!got && n < 200) begin
        @(negedge clk);
        if (!Reset) break;
        if (ackOf(id)) got = 1'b1;
        n++;
      end
      if (Reset) chk($sformatf("ack_wait_%0d", id), got, 1);
      @(posedge clk); #1;
      drive(id, 1'b0, c);
      act[id] = 1'b0;
    end
  endtask

  // Reference model: one access at a time, MEM_LAT+2 cycles each, priority rules applied per grant
  always @(posedge clk or negedge Reset) begin
    exp_t e;
    if (!Reset) begin
      busy = 0; starve = 0; fStallCnt = 0; dStallCnt = 0;
      issQ.delete(); ackQ.delete();
    end else begin
      if (FetchReq && !FetchAck) fStallCnt++;
      if (DataReq && !DataAck) dStallCnt++;
      if (busy > 0) busy--;
      else begin
        if (!FetchReq) starve = 0;
        if (LoadReq || DataReq || FetchReq) begin
          if (LoadReq) e.who = 0;
          else if (DataReq && FetchReq) e.who = (starve == STARVE_LIMIT) ? 2 : 1;
          else if (DataReq) e.who = 1;
          else e.who = 2;
          if (e.who == 2) starve = 0;
          else if (e.who == 1 && FetchReq && starve < STARVE_LIMIT) starve++;
          e.addr  = (e.who == 0) ? LoadAddr : (e.who == 1) ? DataAddr : FetchAddr;
          e.we    = (e.who == 0) ? 1'b1 : (e.who == 1) ? DataWe : 1'b0;
          e.wdata = (e.who == 0) ? LoadWData : DataWData;
          e.rdata = '0;
          if (e.we) shadow[e.addr[5:0]] = e.wdata;
          else e.rdata = shadow[e.addr[5:0]];
          e.cyc = cyc + 1;
          issQ.push_back(e);
          e.cyc = cyc + 1 + MEM_LAT;
          ackQ.push_back(e);
          busy = MEM_LAT + 1;
        end
      end
      cyc++;
    end
  end

  // Monitor: compares memory issues and acks against the scoreboard queues
  always @(negedge clk) begin
    exp_t e;
    int who;
    logic [DW-1:0] rd;
    if (Reset) begin
      chk("one_ack", (32'(LoadAck) + 32'(DataAck) + 32'(FetchAck)) <= 32'd1, 1);
      chk("fetch_stall", FetchStall, FetchReq & ~FetchAck);
      chk("data_stall", DataStall, DataReq & ~DataAck);
      if (MemEn) begin
        memEnCnt++;
        if (MemWe) weLog = {weLog, "1"};
        else weLog = {weLog, "0"};
        if (issQ.size() == 0) chk("issue_unexpected", 0, 1);
        else begin
          e = issQ.pop_front();
          chk("issue_cyc", cyc, e.cyc);
          chk("issue_addr", MemAddr, e.addr);
          chk("issue_we", MemWe, e.we);
          if (e.we) chk("issue_wdata", MemWData, e.wdata);
        end
      end
      if (LoadAck || DataAck || FetchAck) begin
        who = LoadAck ? 0 : DataAck ? 1 : 2;
        rd = (who == 2) ? FetchRData : DataRData;
        if (who == 0) ackLog = {ackLog, "L"};
        else if (who == 1) begin ackLog = {ackLog, "D"}; lastData = rd; end
        else begin ackLog = {ackLog, "F"}; lastFetch = rd; end
        if (ackQ.size() == 0) chk("ack_unexpected", 0, 1);
        else begin
          e = ackQ.pop_front();
          chk("ack_who", who, e.who);
          chk("ack_cyc", cyc, e.cyc);
          if (!e.we) chk("ack_rdata", rd, e.rdata);
        end
      end
      if (issQ.size() != 0 && issQ[0].cyc < cyc) begin
        chk("issue_missing", 0, 1);
        void'(issQ.pop_front());
      end
      if (ackQ.size() != 0 && ackQ[0].cyc < cyc) begin
        chk("ack_missing", 0, 1);
        void'(ackQ.pop_front());
      end
    end
  end

  task automatic drain(input string name, input int limit);
    int n = 0;
    @(posedge clk); #2;
    while ((qsize(0) + qsize(1) + qsize(2) != 0 || act[0] || act[1] || act[2] || busy != 0) && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_drain"}, n < limit, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int m0, n;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA500_0000 | i;
      shadow[i] = 32'hA500_0000 | i;
    end
    mem[16] = 32'hDEAD_BEEF;
    shadow[16] = 32'hDEAD_BEEF;
    fork
      serve(0);
      serve(1);
      serve(2);
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_memen", MemEn, 0);
    chk("rst_memwe", MemWe, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_memwdata", MemWData, 0);
    chk("rst_acks", {LoadAck, DataAck, FetchAck}, 0);
    @(negedge clk) Reset = 1'b1;
    @(posedge clk); #2;

    fq.push_back(mk('h10, 0, '0, 0));
    drain("single_fetch", 100);
    chk("single_fetch_rdata", lastFetch, 32'hDEAD_BEEF);

    ackLog = ""; m0 = memEnCnt;
    lq.push_back(mk(3, 1, 32'h0BAD_F00D, 0));
    dq.push_back(mk(4, 0, '0, 0));
    fq.push_back(mk(5, 0, '0, 0));
    drain("all_three", 200);
    chkStr("all_three_order", ackLog, "LDF");
    chk("all_three_memen", memEnCnt - m0, 3);

    ackLog = "";
    for (int i = 0; i < 6; i++) dq.push_back(mk(32 + i, 0, '0, 0));
    for (int i = 0; i < 2; i++) fq.push_back(mk(40 + i, 0, '0, 0));
    drain("starve", 400);
    chkStr("starve_order", ackLog, "DDDDFDDF");

    weLog = "";
    dq.push_back(mk('h20, 1, 32'h1234_5678, 0));
    dq.push_back(mk('h20, 0, '0, 0));
    drain("store_load", 200);
    chk("store_load_rdata", lastData, 32'h1234_5678);
    chkStr("store_load_we", weLog, "10");

    fq.push_back(mk(5, 0, '0, 0));
    n = 0;
    while (!MemEn && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reset_wait_issue", n < 50, 1);
    @(posedge clk); #2;
    Reset = 1'b0;
    #1;
    chk("rst_wait_acks", {LoadAck, DataAck, FetchAck}, 0);
    chk("rst_wait_memen", MemEn, 0);
    chk("rst_wait_memaddr", MemAddr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) Reset = 1'b1;
    @(posedge clk); #2;
    lastFetch = '0;
    fq.push_back(mk('h10, 0, '0, 0));
    drain("after_reset", 100);
    chk("after_reset_rdata", lastFetch, 32'hDEAD_BEEF);

    for (int i = 0; i < 12; i++)
      lq.push_back(mk($urandom_range(0, 63), 1, $urandom, $urandom_range(0, 4)));
    for (int i = 0; i < 30; i++)
      dq.push_back(mk($urandom_range(0, 63), $urandom_range(0, 1), $urandom, $urandom_range(0, 3)));
    for (int i = 0; i < 30; i++)
      fq.push_back(mk($urandom_range(0, 63), 0, '0, $urandom_range(0, 3)));
    drain("random", 5000);

    repeat (3) @(posedge clk);
    #2;
    chk("final_issq_empty", issQ.size(), 0);
    chk("final_ackq_empty", ackQ.size(), 0);
`ifdef ARB_PERF_CNT_EN
    chk("fetch_stall_cnt", FetchStallCnt, fStallCnt);
    chk("data_stall_cnt", DataStallCnt, dStallCnt);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
